// File: rtl/wb_ext_arbiter_pkg.sv
// Shared types for the external Wishbone arbiter: FSM state encoding,
// Wishbone B3 cycle-type / burst-type codes and a pointer-width helper.
package wb_ext_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    // Cycle type identifiers (cti)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Burst type extensions (bte)
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Width of a master index; a single master still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_ext_arbiter_if.sv
// Bus bundle between the per-tile wb_ext masters, the arbiter and the single
// external slave. Master signals are flattened, master k at [k*W +: W].
interface wb_ext_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    localparam int SW = DW / 8;

    // master side
    logic [NUM_MASTERS*AW-1:0] m_adr_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_i;
    logic [NUM_MASTERS*SW-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS-1:0]    m_cab_i;
    logic [NUM_MASTERS*3-1:0]  m_cti_i;
    logic [NUM_MASTERS*2-1:0]  m_bte_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic [NUM_MASTERS-1:0]    m_rty_o;

    // slave side
    logic [AW-1:0]             s_adr_o;
    logic [DW-1:0]             s_dat_o;
    logic [SW-1:0]             s_sel_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic                      s_we_o;
    logic                      s_cab_o;
    logic [2:0]                s_cti_o;
    logic [1:0]                s_bte_o;
    logic [DW-1:0]             s_dat_i;
    logic                      s_ack_i;
    logic                      s_err_i;
    logic                      s_rty_i;

    // arbiter view: slave to the tiles, master to the external device
    modport arb (
        input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cab_i,
               m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o,
               s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    // the tile masters
    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cab_i,
               m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o
    );

    // the external slave
    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o, s_cab_o,
               s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

endinterface

// File: rtl/wb_ext_arbiter_rr.sv
// Combinational rotating-priority selector: searches the request vector
// upward from ptr_i+1 (wrapping) and returns the first hit as one-hot.
module wb_ext_arb_rr
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]               req_i,
    input  logic [ptr_width(NUM_MASTERS)-1:0]    ptr_i,
    output logic [NUM_MASTERS-1:0]               gnt_o
);
    localparam int PTR_W = ptr_width(NUM_MASTERS);

    logic             found;
    logic [PTR_W-1:0] idx;

    // first requester after the last owner; the last owner itself comes last
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % NUM_MASTERS);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter sharing one external Wishbone slave between the
// per-tile wb_ext masters. The grant is held for the whole cyc (bursts too);
// the request path to the slave is a combinational mux on the registered grant.
// Optional stall watchdog: define OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN.
module wb_ext_arbiter
    import wb_ext_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_ext_arbiter_if.arb          bus,
    output logic [NUM_MASTERS-1:0] grant_o
);
    localparam int SW    = DW / 8;
    localparam int PTR_W = ptr_width(NUM_MASTERS);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [NUM_MASTERS-1:0] next_gnt;
    logic [PTR_W-1:0]       gidx;
    logic                   gnt_cyc;
    logic                   gnt_stb;
    logic                   fwd;

    logic [AW-1:0]          adr_m;
    logic [DW-1:0]          dat_m;
    logic [SW-1:0]          sel_m;
    logic                   we_m;
    logic                   cab_m;
    logic [2:0]             cti_m;
    logic [1:0]             bte_m;

`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_MASTERS-1:0] err_q;
    logic                   term;

    assign term = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
`else
    // The watchdog is compiled out; the timeout parameter has no effect.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    wb_ext_arb_rr #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .req_i (bus.m_cyc_i),
        .ptr_i (ptr_q),
        .gnt_o (next_gnt)
    );

    // AND-OR mux of the granted master's request, plus its index
    always_comb begin
        adr_m = '0;
        dat_m = '0;
        sel_m = '0;
        we_m  = 1'b0;
        cab_m = 1'b0;
        cti_m = '0;
        bte_m = '0;
        gidx  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                adr_m = adr_m | bus.m_adr_i[k*AW +: AW];
                dat_m = dat_m | bus.m_dat_i[k*DW +: DW];
                sel_m = sel_m | bus.m_sel_i[k*SW +: SW];
                we_m  = we_m  | bus.m_we_i[k];
                cab_m = cab_m | bus.m_cab_i[k];
                cti_m = cti_m | bus.m_cti_i[k*3 +: 3];
                bte_m = bte_m | bus.m_bte_i[k*2 +: 2];
                gidx  = PTR_W'(k);
            end
        end
    end

    assign gnt_cyc = |(grant_q & bus.m_cyc_i);
    assign gnt_stb = |(grant_q & bus.m_stb_i);

    // Forwarding only in GRANT; reset silences the bus in the same cycle.
    assign fwd = (state_q == ST_GRANT) && !rst;

    assign bus.s_cyc_o = fwd & gnt_cyc;
    assign bus.s_stb_o = fwd & gnt_stb;
    assign bus.s_adr_o = fwd ? adr_m : '0;
    assign bus.s_dat_o = fwd ? dat_m : '0;
    assign bus.s_sel_o = fwd ? sel_m : '0;
    assign bus.s_we_o  = fwd & we_m;
    assign bus.s_cab_o = fwd & cab_m;
    assign bus.s_cti_o = fwd ? cti_m : '0;
    assign bus.s_bte_o = fwd ? bte_m : '0;

    assign bus.m_dat_o = {NUM_MASTERS{bus.s_dat_i}};
    assign bus.m_ack_o = fwd ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
    assign bus.m_rty_o = fwd ? (grant_q & {NUM_MASTERS{bus.s_rty_i}}) : '0;
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
    assign bus.m_err_o = (fwd ? (grant_q & {NUM_MASTERS{bus.s_err_i}}) : '0)
                       | (rst ? '0 : err_q);
`else
    assign bus.m_err_o = fwd ? (grant_q & {NUM_MASTERS{bus.s_err_i}}) : '0;
`endif

    assign grant_o = grant_q;

    // Arbitration FSM: grant on request, hold for the cycle, release via IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_MASTERS - 1);
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
            err_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (|bus.m_cyc_i) begin
                        grant_q <= next_gnt;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!gnt_cyc) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= gidx;
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (term) begin
                        cnt_q   <= '0;
                    end else if (gnt_stb) begin
                        // the stall reaching the limit aborts with one err pulse
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= ST_ABORT;
                            err_q   <= grant_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
                ST_ABORT: begin
                    // slave silenced; wait for the master to give up its cycle
                    if (!gnt_cyc) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= gidx;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Self-checking bench for wb_ext_arbiter: directed scenarios plus a random
// phase checked against an ownership/last-owner reference model.
module tb_wb_ext_arbiter;
    import wb_ext_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_ext_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();
    logic [N-1:0] grant;

    wb_ext_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_o(grant)
    );

    logic [N-1:0]  mcyc, mstb, mwe, mcab;
    logic [AW-1:0] madr [N];
    logic [DW-1:0] mdat [N];
    logic [SW-1:0] msel [N];
    logic [2:0]    mcti [N];
    logic [1:0]    mbte [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.m_adr_i[k*AW +: AW] = madr[k];
            bus.m_dat_i[k*DW +: DW] = mdat[k];
            bus.m_sel_i[k*SW +: SW] = msel[k];
            bus.m_cti_i[k*3 +: 3]   = mcti[k];
            bus.m_bte_i[k*2 +: 2]   = mbte[k];
        end
    end
    assign bus.m_cyc_i = mcyc;
    assign bus.m_stb_i = mstb;
    assign bus.m_we_i  = mwe;
    assign bus.m_cab_i = mcab;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        mcyc = '0; mstb = '0; mwe = '0; mcab = '0;
        for (int k = 0; k < N; k++) begin
            madr[k] = AW'(32'h1000_0000 + k * 32'h100);
            mdat[k] = DW'(32'hD000_0000 + k);
            msel[k] = '1;
            mcti[k] = CTI_CLASSIC;
            mbte[k] = BTE_LINEAR;
        end
        bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
        bus.s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // rotating priority: first requester after the last owner
    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0] err_seen;
        int own, last, nown, nlast, stall, sel, m, r;
        int beats [N];
        logic [N-1:0] drop;
        logic ack, err, rty;

        clear_masters();
        rst = 1'b1;
        tick(); tick();
        // ---- reset state
        chk("rst_grant", grant, 0);
        chk("rst_s_cyc", bus.s_cyc_o, 0);
        chk("rst_s_stb", bus.s_stb_o, 0);
        chk("rst_m_ack", bus.m_ack_o, 0);
        chk("rst_m_err", bus.m_err_o, 0);
        rst = 1'b0;

        // ---- single request from master 2
        mcyc[2] = 1'b1; mstb[2] = 1'b1; madr[2] = 32'hA000_0208;
        tick();
        chk("t1_grant", grant, 4'b0100);
        chk("t1_s_cyc", bus.s_cyc_o, 1);
        chk("t1_s_adr", bus.s_adr_o, 32'hA000_0208);
        bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h5A5A_1234;
        #1;
        chk("t1_m_ack", bus.m_ack_o, 4'b0100);
        chk("t1_m_dat3", bus.m_dat_o[3*DW +: DW], 32'h5A5A_1234);
        tick();
        bus.s_ack_i = 1'b0;
        mcyc[2] = 1'b0; mstb[2] = 1'b0;
        #1;
        chk("t1_drop_s_cyc", bus.s_cyc_o, 0);
        tick();
        chk("t1_release", grant, 0);

        // ---- all four request; order 0,1,2,3,0 with a dead cycle each
        clear_masters();
        do_reset();
        mcyc = '1; mstb = '1;
        for (int i = 0; i < 5; i++) begin
            m = i % N;
            tick();
            chk("t2_grant", grant, oh(m));
            chk("t2_s_adr", bus.s_adr_o, madr[m]);
            bus.s_ack_i = 1'b1;
            #1;
            chk("t2_m_ack", bus.m_ack_o, oh(m));
            tick();
            bus.s_ack_i = 1'b0;
            mcyc[m] = 1'b0; mstb[m] = 1'b0;
            tick();
            chk("t2_dead", grant, 0);
            mcyc[m] = 1'b1; mstb[m] = 1'b1;
        end
        clear_masters();
        tick();

        // ---- master 1 bursts 4 beats while master 3 waits
        do_reset();
        mcyc[1] = 1'b1; mstb[1] = 1'b1; mcab[1] = 1'b1;
        mcyc[3] = 1'b1; mstb[3] = 1'b1;
        tick();
        chk("t3_grant1", grant, 4'b0010);
        for (int b = 0; b < 4; b++) begin
            mcti[1] = (b < 3) ? CTI_INCR : CTI_END;
            madr[1] = AW'(32'h2000_0000 + b * 4);
            bus.s_ack_i = 1'b1;
            #1;
            chk("t3_s_cti", bus.s_cti_o, mcti[1]);
            chk("t3_s_adr", bus.s_adr_o, madr[1]);
            chk("t3_m_ack", bus.m_ack_o, 4'b0010);
            tick();
            chk("t3_held", grant, 4'b0010);
        end
        bus.s_ack_i = 1'b0;
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        #1;
        chk("t3_s_cyc_fall", bus.s_cyc_o, 0);
        tick();
        chk("t3_idle", grant, 0);
        tick();
        chk("t3_grant3", grant, 4'b1000);
        clear_masters();
        tick();

        // ---- reset during a stalled read of master 0
        do_reset();
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        tick();
        chk("t4_grant0", grant, 4'b0001);
        tick(); tick();
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        rst = 1'b1; bus.s_ack_i = 1'b1;
        #1;
        chk("t4_rst_s_cyc", bus.s_cyc_o, 0);
        chk("t4_rst_m_ack", bus.m_ack_o, 0);
        tick();
        chk("t4_rst_grant", grant, 0);
        chk("t4_rst_ack2", bus.m_ack_o, 0);
        rst = 1'b0; bus.s_ack_i = 1'b0;
        tick();
        chk("t4_regrant0", grant, 4'b0001);
        clear_masters();
        tick(); tick();

        // ---- slave never answers master 2
        do_reset();
        mcyc[2] = 1'b1; mstb[2] = 1'b1;
        tick();
        chk("t5_grant", grant, 4'b0100);
        chk("t5_s_stb", bus.s_stb_o, 1);
        err_seen = '0;
`ifdef OPTIMSOC_WB_EXT_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            tick();
            err_seen = err_seen | bus.m_err_o;
        end
        chk("t5_no_early_err", err_seen, 0);
        chk("t5_pre_s_cyc", bus.s_cyc_o, 1);
        tick();
        chk("t5_err_pulse", bus.m_err_o, 4'b0100);
        chk("t5_abort_s_cyc", bus.s_cyc_o, 0);
        chk("t5_abort_s_stb", bus.s_stb_o, 0);
        bus.s_ack_i = 1'b1;
        #1;
        chk("t5_abort_no_ack", bus.m_ack_o, 0);
        tick();
        chk("t5_err_once", bus.m_err_o, 0);
        chk("t5_abort_hold", bus.s_cyc_o, 0);
        bus.s_ack_i = 1'b0;
        tick(); tick();
        chk("t5_abort_hold2", bus.s_cyc_o, 0);
`else
        for (int c = 0; c < 2000; c++) begin
            tick();
            err_seen = err_seen | bus.m_err_o;
        end
        chk("t5_no_err", err_seen, 0);
        chk("t5_held", grant, 4'b0100);
        chk("t5_s_cyc", bus.s_cyc_o, 1);
`endif
        mcyc[2] = 1'b0; mstb[2] = 1'b0;
        tick();
        chk("t5_release", grant, 0);

        // ---- random traffic against the ownership model
        clear_masters();
        do_reset();
        own = -1; last = N - 1; stall = 0; drop = '0;
        for (int k = 0; k < N; k++) beats[k] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_grant", grant, oh(own));
            for (int k = 0; k < N; k++) begin
                if (!mcyc[k] && !drop[k] && $urandom_range(0, 3) == 0) begin
                    mcyc[k]  = 1'b1; mstb[k] = 1'b1;
                    madr[k]  = $urandom;
                    mdat[k]  = $urandom;
                    mwe[k]   = 1'($urandom_range(0, 1));
                    beats[k] = $urandom_range(1, 3);
                end
            end
            drop = '0;
            ack = 1'b0; err = 1'b0; rty = 1'b0;
            if (own >= 0 && mcyc[own] && mstb[own]) begin
                if (stall >= 3 || $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 7);
                    if (r == 0)      err = 1'b1;
                    else if (r == 1) rty = 1'b1;
                    else             ack = 1'b1;
                end
            end
            bus.s_ack_i = ack; bus.s_err_i = err; bus.s_rty_i = rty;
            bus.s_dat_i = $urandom;
            #1;
            if (own >= 0 && mcyc[own]) begin
                chk("rnd_s_cyc", bus.s_cyc_o, 1);
                chk("rnd_s_adr", bus.s_adr_o, madr[own]);
                chk("rnd_s_dat", bus.s_dat_o, mdat[own]);
                chk("rnd_s_we", bus.s_we_o, mwe[own]);
            end else begin
                chk("rnd_s_cyc_idle", bus.s_cyc_o, 0);
            end
            chk("rnd_m_ack", bus.m_ack_o, ack ? oh(own) : '0);
            chk("rnd_m_err", bus.m_err_o, err ? oh(own) : '0);
            chk("rnd_m_rty", bus.m_rty_o, rty ? oh(own) : '0);
            sel = $urandom_range(0, N - 1);
            chk("rnd_m_dat", bus.m_dat_o[sel*DW +: DW], bus.s_dat_i);

            if (own >= 0 && mcyc[own] && mstb[own] && !(ack | err | rty)) stall++;
            else stall = 0;
            if (own >= 0 && (ack | err | rty)) begin
                beats[own]--;
                if (beats[own] == 0) drop[own] = 1'b1;
            end
            if (own < 0) begin
                nown = pick(mcyc, last); nlast = last;
            end else if (!mcyc[own]) begin
                nown = -1; nlast = own;
            end else begin
                nown = own; nlast = last;
            end
            tick();
            own = nown; last = nlast;
            for (int k = 0; k < N; k++) begin
                if (drop[k]) begin mcyc[k] = 1'b0; mstb[k] = 1'b0; end
            end
            bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
